// File: rtl/conv_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_feeder
// Brief    : Splits one 64-bit host stream into bias writes, weight writes and
//            pixel beats for the conv engine, and sequences go/done.
//            Optional macro CONV_FEEDER_LAST_CHECK_EN adds the s_last checker.
// Revision : 1.0 - initial release
// ============================================================================
module conv_stream_feeder #(
  parameter int BIAS_CNT_W = 9,
  parameter int WT_CNT_W   = 13,
  parameter int PIX_CNT_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIAS_CNT_W-1:0] cfg_bias_cnt,
  input  logic [WT_CNT_W-1:0]   cfg_wt_cnt,
  input  logic [PIX_CNT_W-1:0]  cfg_pix_cnt,
  output logic                  busy,
  output logic                  done,
  input  logic [63:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
`ifdef CONV_FEEDER_LAST_CHECK_EN
  output logic                  err,
`endif
  output logic                  bias_wr_en,
  output logic [127:0]          bias_wr_data,
  output logic                  bias_wr_addr_rst,
  output logic                  wt_wr_en,
  output logic [71:0]           wt_wr_data,
  output logic                  wt_wr_addr_rst,
  output logic                  conv_go,
  input  logic                  conv_done,
  output logic [63:0]           pixel_in,
  output logic                  pixel_in_valid,
  output logic                  pixel_in_last
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_B_RST = 4'd1,
    S_B_LO  = 4'd2,
    S_B_HI  = 4'd3,
    S_W_RST = 4'd4,
    S_W_LO  = 4'd5,
    S_W_HI  = 4'd6,
    S_GO    = 4'd7,
    S_PIX   = 4'd8,
    S_WAIT  = 4'd9,
    S_FIN   = 4'd10
  } state_t;

  state_t                r_state;
  logic [BIAS_CNT_W-1:0] r_cfg_bias;
  logic [WT_CNT_W-1:0]   r_cfg_wt;
  logic [PIX_CNT_W-1:0]  r_cfg_pix;
  logic [BIAS_CNT_W-1:0] r_bcnt;
  logic [WT_CNT_W-1:0]   r_wcnt;
  logic [PIX_CNT_W-1:0]  r_pcnt;
  logic [63:0]           r_lo;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_bias_we;
  logic [127:0]          r_bias_wd;
  logic                  r_bias_arst;
  logic                  r_wt_we;
  logic [71:0]           r_wt_wd;
  logic                  r_wt_arst;
  logic                  r_go;
  logic [63:0]           r_pix;
  logic                  r_pix_v;
  logic                  r_pix_l;

  logic                  w_ready;
  logic                  w_acc;
  logic                  w_b_final;
  logic                  w_w_final;
  logic                  w_p_final;
  state_t                w_after_bias;

  // Ready is a pure decode of the state register, never of s_valid.
  assign w_ready = (r_state == S_B_LO) || (r_state == S_B_HI) ||
                   (r_state == S_W_LO) || (r_state == S_W_HI) ||
                   (r_state == S_PIX);
  assign w_acc   = s_valid & w_ready;

  assign w_b_final    = (r_bcnt == r_cfg_bias - BIAS_CNT_W'(1));
  assign w_w_final    = (r_wcnt == r_cfg_wt   - WT_CNT_W'(1));
  assign w_p_final    = (r_pcnt == r_cfg_pix  - PIX_CNT_W'(1));
  assign w_after_bias = (r_cfg_wt != '0) ? S_W_RST : S_GO;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cfg_bias  <= '0;
      r_cfg_wt    <= '0;
      r_cfg_pix   <= '0;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_pcnt      <= '0;
      r_lo        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bias_we   <= 1'b0;
      r_bias_wd   <= '0;
      r_bias_arst <= 1'b0;
      r_wt_we     <= 1'b0;
      r_wt_wd     <= '0;
      r_wt_arst   <= 1'b0;
      r_go        <= 1'b0;
      r_pix       <= '0;
      r_pix_v     <= 1'b0;
      r_pix_l     <= 1'b0;
    end else begin
      r_bias_we   <= 1'b0;
      r_bias_arst <= 1'b0;
      r_wt_we     <= 1'b0;
      r_wt_arst   <= 1'b0;
      r_go        <= 1'b0;
      r_pix_v     <= 1'b0;
      r_pix_l     <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg_bias <= cfg_bias_cnt;
            r_cfg_wt   <= cfg_wt_cnt;
            r_cfg_pix  <= cfg_pix_cnt;
            r_bcnt     <= '0;
            r_wcnt     <= '0;
            r_pcnt     <= '0;
            r_busy     <= 1'b1;
            if (cfg_bias_cnt != '0)    r_state <= S_B_RST;
            else if (cfg_wt_cnt != '0) r_state <= S_W_RST;
            else                       r_state <= S_GO;
          end
        end
        S_B_RST: begin
          r_bias_arst <= 1'b1;
          r_state     <= S_B_LO;
        end
        S_B_LO: begin
          if (w_acc) begin
            r_lo    <= s_data;
            r_state <= S_B_HI;
          end
        end
        S_B_HI: begin
          if (w_acc) begin
            r_bias_we <= 1'b1;
            r_bias_wd <= {s_data, r_lo};
            r_bcnt    <= r_bcnt + BIAS_CNT_W'(1);
            r_state   <= w_b_final ? w_after_bias : S_B_LO;
          end
        end
        S_W_RST: begin
          r_wt_arst <= 1'b1;
          r_state   <= S_W_LO;
        end
        S_W_LO: begin
          if (w_acc) begin
            r_lo    <= s_data;
            r_state <= S_W_HI;
          end
        end
        S_W_HI: begin
          if (w_acc) begin
            r_wt_we <= 1'b1;
            r_wt_wd <= {s_data[7:0], r_lo};
            r_wcnt  <= r_wcnt + WT_CNT_W'(1);
            r_state <= w_w_final ? S_GO : S_W_LO;
          end
        end
        S_GO: begin
          r_go    <= 1'b1;
          r_state <= S_PIX;
        end
        S_PIX: begin
          // No engine backpressure: bubbles on the host side pass through as gaps.
          if (w_acc) begin
            r_pix   <= s_data;
            r_pix_v <= 1'b1;
            r_pcnt  <= r_pcnt + PIX_CNT_W'(1);
            if (w_p_final) begin
              r_pix_l <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (conv_done) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_FEEDER_LAST_CHECK_EN
  logic r_err;
  logic w_final_beat;

  assign w_final_beat = ((r_state == S_B_HI) && w_b_final) ||
                        ((r_state == S_W_HI) && w_w_final) ||
                        ((r_state == S_PIX)  && w_p_final);

  // Sticky framing error: s_last must be present exactly on phase-final beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_err <= 1'b0;
    end else if (w_acc && (s_last != w_final_beat)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_last;
  assign w_unused_last = s_last;
`endif

  assign s_ready          = w_ready;
  assign busy             = r_busy;
  assign done             = r_done;
  assign bias_wr_en       = r_bias_we;
  assign bias_wr_data     = r_bias_wd;
  assign bias_wr_addr_rst = r_bias_arst;
  assign wt_wr_en         = r_wt_we;
  assign wt_wr_data       = r_wt_wd;
  assign wt_wr_addr_rst   = r_wt_arst;
  assign conv_go          = r_go;
  assign pixel_in         = r_pix;
  assign pixel_in_valid   = r_pix_v;
  assign pixel_in_last    = r_pix_l;

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_stream_feeder
// Brief    : Directed bench for conv_stream_feeder with a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_stream_feeder;

  localparam int BW = 9;
  localparam int WW = 13;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] cfg_bias_cnt;
  logic [WW-1:0] cfg_wt_cnt;
  logic [PW-1:0] cfg_pix_cnt;
  logic          busy, done;
  logic [63:0]   s_data;
  logic          s_valid, s_ready, s_last;
  logic          bias_wr_en, bias_wr_addr_rst;
  logic [127:0]  bias_wr_data;
  logic          wt_wr_en, wt_wr_addr_rst;
  logic [71:0]   wt_wr_data;
  logic          conv_go, conv_done;
  logic [63:0]   pixel_in;
  logic          pixel_in_valid, pixel_in_last;
`ifdef CONV_FEEDER_LAST_CHECK_EN
  logic          err;
`endif

  conv_stream_feeder #(.BIAS_CNT_W(BW), .WT_CNT_W(WW), .PIX_CNT_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_bias_cnt(cfg_bias_cnt), .cfg_wt_cnt(cfg_wt_cnt), .cfg_pix_cnt(cfg_pix_cnt),
    .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
`ifdef CONV_FEEDER_LAST_CHECK_EN
    .err(err),
`endif
    .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data), .bias_wr_addr_rst(bias_wr_addr_rst),
    .wt_wr_en(wt_wr_en), .wt_wr_data(wt_wr_data), .wt_wr_addr_rst(wt_wr_addr_rst),
    .conv_go(conv_go), .conv_done(conv_done),
    .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid), .pixel_in_last(pixel_in_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stream-level model: beat k of a load is classified purely by its index.
  logic [63:0] beats [0:63];
  logic [63:0] src_d [$];
  logic        src_l [$];
  bit          gap_mode = 1'b0;
  bit          flush = 1'b0;
  bit          mon_en = 1'b0;
  int          m_bias, m_wt, m_np, m_total, m_k, p_k;
  bit          p_acc = 1'b0;
  int          load_id = 0;
  int          n_brst, n_bwe, n_wrst, n_wwe, n_go, n_piv, n_pil, n_done;
  int          go_cyc, done_cyc, s_cyc;
  bit          saw_last, busy_at_done;
  logic [127:0] first_bias;
  logic [71:0]  first_wt;
  logic [63:0]  last_pix;
  bit          e_bwe, e_wwe, e_piv, e_pil;
  logic [5:0]  i0, i1;

  // Source: presents queued beats, optionally only on alternate cycles.
  initial begin
    bit acc;
    bit tog;
    tog = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    forever begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (flush) begin
        src_d.delete();
        src_l.delete();
        flush = 1'b0;
      end else if (acc && src_d.size() > 0) begin
        void'(src_d.pop_front());
        void'(src_l.pop_front());
      end
      tog = ~tog;
      if (src_d.size() > 0 && (!gap_mode || tog)) begin
        s_valid = 1'b1;
        s_data  = src_d[0];
        s_last  = src_l[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // Compare process: every cycle, strobes/data must reflect the previous accept.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        e_bwe = p_acc && (p_k < 2*m_bias) && (p_k % 2 == 1);
        e_wwe = p_acc && (p_k >= 2*m_bias) && (p_k < 2*(m_bias+m_wt)) && ((p_k - 2*m_bias) % 2 == 1);
        e_piv = p_acc && (p_k >= 2*(m_bias+m_wt));
        e_pil = e_piv && (p_k == m_total - 1);
        i0 = 6'(p_k);
        i1 = 6'(p_k - 1);
        chk("bias_wr_en", 128'(bias_wr_en), 128'(e_bwe));
        chk("wt_wr_en", 128'(wt_wr_en), 128'(e_wwe));
        chk("pixel_in_valid", 128'(pixel_in_valid), 128'(e_piv));
        chk("pixel_in_last", 128'(pixel_in_last), 128'(e_pil));
        if (e_bwe) chk("bias_wr_data", bias_wr_data, {beats[i0], beats[i1]});
        if (e_wwe) chk("wt_wr_data", 128'(wt_wr_data), 128'({beats[i0][7:0], beats[i1]}));
        if (e_piv) chk("pixel_in", 128'(pixel_in), 128'(beats[i0]));
        if (bias_wr_en) begin n_bwe++; if (n_bwe == 1) first_bias = bias_wr_data; end
        if (wt_wr_en) begin n_wwe++; if (n_wwe == 1) first_wt = wt_wr_data; end
        if (bias_wr_addr_rst) n_brst++;
        if (wt_wr_addr_rst) n_wrst++;
        if (conv_go) begin n_go++; go_cyc = cyc; end
        if (pixel_in_valid) n_piv++;
        if (pixel_in_last) begin n_pil++; saw_last = 1'b1; last_pix = pixel_in; end
        if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
      end
      p_acc = s_valid && s_ready && !rst;
      p_k   = m_k;
      if (p_acc) m_k++;
    end
  end

  task automatic load_begin(input int nb, input int nw, input int np, input bit gaps, input int bad_idx);
    int tot;
    bit lst;
    tot = 2*nb + 2*nw + np;
    load_id++;
    m_bias = nb; m_wt = nw; m_np = np; m_total = tot; m_k = 0; p_acc = 1'b0;
    n_brst = 0; n_bwe = 0; n_wrst = 0; n_wwe = 0; n_go = 0; n_piv = 0; n_pil = 0; n_done = 0;
    go_cyc = -1; done_cyc = -1; saw_last = 1'b0; busy_at_done = 1'b1;
    gap_mode = gaps;
    for (int k = 0; k < tot; k++) begin
      beats[6'(k)] = {16'hC0DE, 8'(load_id), 8'(k), 24'(k * 24'h010101) ^ 24'h5A5A00, 8'(k*7 + 3)};
      lst = (nb > 0 && k == 2*nb - 1) || (nw > 0 && k == 2*(nb+nw) - 1) || (k == tot - 1) || (k == bad_idx);
      src_d.push_back(beats[6'(k)]);
      src_l.push_back(lst);
    end
    @(posedge clk); #1;
    cfg_bias_cnt = BW'(nb);
    cfg_wt_cnt   = WW'(nw);
    cfg_pix_cnt  = PW'(np);
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_bias_cnt = '1;
    cfg_wt_cnt   = '1;
    cfg_pix_cnt  = '1;
    @(negedge clk);
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic load_finish(input bit coincide);
    int t;
    int d_cyc;
    t = 0;
    if (coincide) begin
      while (src_d.size() > 0 && t < 400) begin @(posedge clk); #2; t++; end
    end else begin
      while (!saw_last && t < 400) begin @(posedge clk); #2; t++; end
      @(posedge clk); #1;
    end
    chk("pixel_phase_in_time", 128'(t < 400), 128'(1));
    conv_done = 1'b1;
    d_cyc = cyc;
    @(posedge clk); #1;
    conv_done = 1'b0;
    t = 0;
    while (n_done == 0 && t < 50) begin @(negedge clk); t++; end
    chk("done_latency", 128'(done_cyc - d_cyc), 128'(1));
    chk("busy_at_done", 128'(busy_at_done), 128'(0));
    repeat (3) @(negedge clk);
    chk("n_bias_rst", 128'(n_brst), 128'(m_bias > 0));
    chk("n_bias_wr", 128'(n_bwe), 128'(m_bias));
    chk("n_wt_rst", 128'(n_wrst), 128'(m_wt > 0));
    chk("n_wt_wr", 128'(n_wwe), 128'(m_wt));
    chk("n_conv_go", 128'(n_go), 128'(1));
    chk("n_pixels", 128'(n_piv), 128'(m_np));
    chk("n_pixel_last", 128'(n_pil), 128'(1));
    chk("n_done", 128'(n_done), 128'(1));
    chk("busy_idle", 128'(busy), 128'(0));
    if (m_bias == 0 && m_wt == 0) chk("go_after_start", 128'(go_cyc - s_cyc), 128'(2));
  endtask

  task automatic run_load(input int nb, input int nw, input int np, input bit gaps,
                          input bit coincide, input int bad_idx);
    load_begin(nb, nw, np, gaps, bad_idx);
    load_finish(coincide);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, 128'({busy, done, s_ready, bias_wr_en, bias_wr_addr_rst, wt_wr_en,
                                 wt_wr_addr_rst, conv_go, pixel_in_valid, pixel_in_last}), 128'(0));
    chk({tag, "_bias_data"}, bias_wr_data, 128'(0));
    chk({tag, "_wt_data"}, 128'(wt_wr_data), 128'(0));
    chk({tag, "_pixel"}, 128'(pixel_in), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int snap;
    rst = 1'b1; start = 1'b0; conv_done = 1'b0;
    cfg_bias_cnt = '0; cfg_wt_cnt = '0; cfg_pix_cnt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
`ifdef CONV_FEEDER_LAST_CHECK_EN
    chk("err_reset", 128'(err), 128'(0));
`endif
    mon_en = 1'b1;

    // Full load: 2 bias entries, 3 weight words, 4 pixels.
    run_load(2, 3, 4, 1'b0, 1'b0, -1);
    chk("bias0_literal", first_bias, 128'hC0DE01015B5B010A_C0DE01005A5A0003);
    chk("wt0_literal", 128'(first_wt), 128'(72'h26_C0DE01045E5E041F));
    chk("last_pixel_literal", 128'(last_pix), 128'(64'hC0DE010D57570D5E));
`ifdef CONV_FEEDER_LAST_CHECK_EN
    chk("err_clean_load", 128'(err), 128'(0));
`endif

    // Pixel-only load, go two cycles after start.
    run_load(0, 0, 1, 1'b0, 1'b0, -1);
    // Toggling valid during pixel phase.
    run_load(0, 0, 6, 1'b1, 1'b0, -1);
    // conv_done coincident with the final pixel output.
    run_load(1, 1, 3, 1'b0, 1'b1, -1);

    // Reset in the middle of the weight phase.
    load_begin(1, 3, 2, 1'b0, -1);
    t = 0;
    while (n_wwe < 1 && t < 100) begin @(negedge clk); t++; end
    chk("reached_first_wt", 128'(n_wwe), 128'(1));
    @(posedge clk);
    flush = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    snap = n_wwe;
    repeat (5) @(negedge clk);
    chk("no_wr_after_rst", 128'(n_wwe), 128'(snap));
    chk("no_pix_after_rst", 128'(n_piv), 128'(0));
    run_load(1, 2, 2, 1'b0, 1'b0, -1);

`ifdef CONV_FEEDER_LAST_CHECK_EN
    // Stray s_last on pixel 2 of 4; err sticks, stream unchanged.
    run_load(0, 0, 4, 1'b0, 1'b0, 1);
    chk("err_stray_last", 128'(err), 128'(1));
    repeat (3) @(negedge clk);
    chk("err_sticky", 128'(err), 128'(1));
    run_load(0, 0, 2, 1'b0, 1'b0, -1);
    chk("err_cleared_by_start", 128'(err), 128'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
